des_sbox_array: RTL and testbench

Parametrised DES substitution stage that replaces the single-S-box lookup with a full S1–S8 layer. It converts the 48-bit post-key-mix half-block into the 32-bit S-layer output. The layer is time-multiplexed over `LANES` parallel lookup lanes and wrapped in valid/ready handshakes. It sits in the round datapath between the key XOR and the P permutation, and lets area/throughput be traded per build.

---
 rtl/des_pkg.sv | 33 +++
 rtl/des_sbox_lane.sv | 12 +
 rtl/des_sbox_array.sv | 84 ++++++++
 tb/tb_des_sbox_array.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types, the FIPS 46-3 S-box tables and the row/column-remapped lookup
// used by every lane of the DES S-layer.
package des_pkg;

  localparam int NUM_SBOX = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // SBOX[box][index]: each 256-bit word is one table, entry 0 in the top nibble.
  localparam logic [0:NUM_SBOX-1][0:63][3:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Outer bits {b1,b6} select the row, inner bits b2..b5 the column.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box_idx,
                                             input logic [5:0] chunk);
    logic [5:0] idx;
    idx = {chunk[5], chunk[0], chunk[4:1]};
    return SBOX[box_idx][idx];
  endfunction

endpackage

// File: rtl/des_sbox_lane.sv
// One combinational S-box lookup lane; the box it serves is chosen per cycle.
module des_sbox_lane
  import des_pkg::*;
(
  input  logic [2:0] box_idx,
  input  logic [5:0] chunk,
  output logic [3:0] nibble
);

  assign nibble = sbox_lookup(box_idx, chunk);

endmodule

// File: rtl/des_sbox_array.sv
// DES S1-S8 layer evaluated LANES boxes per cycle behind valid/ready handshakes.
// States: IDLE = waiting for a block | BUSY = NGRP lookup cycles | DONE = result held on dout
module des_sbox_array
  import des_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout,
  output logic        busy
);

  localparam int NGRP = NUM_SBOX / LANES;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_array: LANES must be 1, 2, 4 or 8");
  end

  state_e                r_state;
  state_e                w_state_nxt;
  logic [GW-1:0]         r_grp;
  logic [0:7][5:0]       r_din_q;
  logic [0:7][3:0]       r_res_q;
  logic                  w_accept;
  logic                  w_last_grp;
  logic [2:0]            w_box [LANES];
  logic [3:0]            w_nib [LANES];

  assign w_accept   = in_valid && in_ready;
  assign w_last_grp = (r_grp == GW'(NGRP - 1));

  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_BUSY);
  assign dout      = r_res_q;

  // Lane k serves box grp*LANES+k this cycle.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_box[k] = 3'(int'(r_grp) * LANES + k);
    des_sbox_lane u_lane (
      .box_idx (w_box[k]),
      .chunk   (r_din_q[w_box[k]]),
      .nibble  (w_nib[k])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)   w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_last_grp) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)  w_state_nxt = in_valid ? ST_BUSY : ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grp   <= '0;
      r_din_q <= '0;
      r_res_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_din_q <= din;
        r_grp   <= '0;
      end else if (r_state == ST_BUSY) begin
        r_grp <= w_last_grp ? '0 : r_grp + 1'b1;
        for (int k = 0; k < LANES; k++) begin
          r_res_q[w_box[k]] <= w_nib[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_des_sbox_array.sv
// Directed plus randomized checks of des_sbox_array for LANES = 1, 2, 4, 8,
// against an independent table-driven model of the DES S-layer.
module tb_des_sbox_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [47:0] din       [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [31:0] dout      [4];
  logic        busy      [4];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instance g runs with LANES = 2**g.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_array #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .din       (din[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .dout      (dout[g]),
      .busy      (busy[g])
    );
  end

  // FIPS 46-3 tables as printed: TBL[box][row][col].
  int TBL [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  function automatic logic [31:0] model_slayer(input logic [47:0] d);
    logic [31:0] r;
    int c, row, col;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      c   = int'((d >> (42 - 6 * b)) & 48'h3F);
      row = ((c >> 5) & 1) * 2 + (c & 1);
      col = (c >> 1) & 15;
      r   = (r << 4) | 32'(TBL[b][row][col]);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept_block(input int li, input logic [47:0] d);
    @(negedge clk);
    din[li]      = d;
    in_valid[li] = 1'b1;
    #1;
    check("in_ready_at_accept", in_ready[li], 1);
    @(posedge clk);
    #1 in_valid[li] = 1'b0;
  endtask

  // Returns the number of BUSY cycles seen before out_valid, or -1 on timeout.
  task automatic wait_result(input int li, output int nbusy);
    bit seen = 0;
    nbusy = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (out_valid[li]) seen = 1;
      else if (busy[li]) nbusy++;
    end
    if (!seen) nbusy = -1;
  endtask

  task automatic run_random(input int li, input int nblk);
    logic [31:0] q[$];
    logic [31:0] held;
    logic [63:0] r64;
    int sent = 0, got = 0, cyc = 0;
    bit hold = 0, acc = 0;
    in_valid[li]  = 1'b0;
    out_ready[li] = 1'b0;
    while (got < nblk && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!in_valid[li] && sent < nblk && $urandom_range(3) != 0) begin
        r64          = {$urandom(), $urandom()};
        din[li]      = r64[47:0];
        in_valid[li] = 1'b1;
      end
      out_ready[li] = ($urandom_range(3) != 0);
      #1;
      if (hold) begin
        check("rand_hold_valid", out_valid[li], 1);
        check("rand_hold_dout", dout[li], held);
      end
      hold = 0;
      if (out_valid[li]) begin
        if (out_ready[li]) begin
          if (q.size() == 0) check("rand_spurious_out", q.size(), 1);
          else check("rand_dout", dout[li], q.pop_front());
          got++;
        end else begin
          hold = 1;
          held = dout[li];
        end
      end
      if (in_valid[li] && in_ready[li]) begin
        q.push_back(model_slayer(din[li]));
        sent++;
        acc = 1;
      end
      @(posedge clk);
      #1;
      if (acc) in_valid[li] = 1'b0;
      acc = 0;
    end
    check("rand_block_count", got, nblk);
    check("rand_leftover", q.size(), 0);
    out_ready[li] = 1'b0;
  endtask

  initial begin
    int nb;
    logic [47:0] x;
    logic [31:0] dq;
    logic [63:0] r64;
    for (int i = 0; i < 4; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      din[i]       = '0;
    end

    // Reset values on every instance
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_in_ready", in_ready[i], 1);
      check("rst_out_valid", out_valid[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_dout", dout[i], 0);
    end

    // LANES=8, all-zero input
    out_ready[3] = 1'b1;
    accept_block(3, 48'h0);
    wait_result(3, nb);
    check("l8_zero_latency", nb, 1);
    check("l8_zero_dout", dout[3], 32'hEFA72C4D);

    // LANES=1, all-ones input
    out_ready[0] = 1'b1;
    accept_block(0, 48'hFFFF_FFFF_FFFF);
    wait_result(0, nb);
    check("l1_ones_busy", nb, 8);
    check("l1_ones_dout", dout[0], 32'hD9CE3DCB);

    // Row/column remap on S1
    accept_block(3, {6'b011011, 42'h0});
    wait_result(3, nb);
    dq = dout[3];
    check("addr_s1_nibble", dq[31:28], 4'h5);
    check("addr_full_dout", dout[3], model_slayer({6'b011011, 42'h0}));

    // LANES=2 backpressure with a waiting upstream block
    out_ready[1] = 1'b0;
    r64 = {$urandom(), $urandom()};
    x   = r64[47:0];
    accept_block(1, x);
    wait_result(1, nb);
    check("bp_busy", nb, 4);
    for (int i = 0; i < 5; i++) begin
      r64          = {$urandom(), $urandom()};
      din[1]       = r64[47:0];
      in_valid[1]  = 1'b1;
      #1;
      check("bp_in_ready_low", in_ready[1], 0);
      check("bp_out_valid", out_valid[1], 1);
      check("bp_dout_stable", dout[1], model_slayer(x));
      @(negedge clk);
    end
    r64          = {$urandom(), $urandom()};
    x            = r64[47:0];
    din[1]       = x;
    out_ready[1] = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready[1], 1);
    @(posedge clk);
    #1 in_valid[1] = 1'b0;
    wait_result(1, nb);
    check("bp_next_busy", nb, 4);
    check("bp_next_dout", dout[1], model_slayer(x));

    // LANES=1 reset while grp = 3
    r64 = {$urandom(), $urandom()};
    accept_block(0, r64[47:0]);
    repeat (3) @(posedge clk);
    #2;
    check("mid_busy_before_rst", busy[0], 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_out_valid", out_valid[0], 0);
    check("mid_rst_dout", dout[0], 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready[0], 1);
    r64 = {$urandom(), $urandom()};
    x   = r64[47:0];
    accept_block(0, x);
    wait_result(0, nb);
    check("post_rst_busy", nb, 8);
    check("post_rst_dout", dout[0], model_slayer(x));
    @(negedge clk);
    out_ready[0] = 1'b0;
    out_ready[3] = 1'b0;
    out_ready[1] = 1'b0;

    // Random stalls on every LANES value
    for (int li = 0; li < 4; li++) run_random(li, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
